// File: rtl/timer_counter.sv
// Countdown timer peripheral on the data-side system bus.
// Three registers (CTRL, PRESET, COUNT) with byte-enabled stores, combinational
// word readback, and a level interrupt raised when the count expires.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PRESET = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  ctrl_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic        pend_r;

    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        one_shot_s;
    logic [3:0]  ctrl_hw_s;
    logic [3:0]  ctrl_next_s;

    // Replace each enabled byte of old_val with the matching byte of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // A store only counts as a write when at least one byte lane is enabled.
    assign wr_ctrl_s   = we && (addr == OFS_CTRL)   && (byteen != 4'b0000);
    assign wr_preset_s = we && (addr == OFS_PRESET) && (byteen != 4'b0000);

    // MODE 01 is the only auto-reload encoding; everything else is one-shot.
    assign one_shot_s  = (ctrl_r[2:1] != 2'b01);

    assign irq = pend_r & ctrl_r[3];

    // Next CTRL: hardware EN clear on one-shot expiry, then software bytes on top.
    always_comb begin
        ctrl_hw_s   = ctrl_r;
        ctrl_next_s = ctrl_r;
        if ((state_r == INT) && one_shot_s) begin
            ctrl_hw_s = {ctrl_r[3:1], 1'b0};
        end else begin
            ctrl_hw_s = ctrl_r;
        end
        if (wr_ctrl_s && byteen[0]) begin
            ctrl_next_s = wdata[3:0];
        end else begin
            ctrl_next_s = ctrl_hw_s;
        end
    end

    // PRESET register: byte-merged software writes only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset_r <= 32'd0;
        end else if (wr_preset_s) begin
            preset_r <= merge_bytes(preset_r, wdata, byteen);
        end else begin
            preset_r <= preset_r;
        end
    end

    // Countdown FSM with CTRL, COUNT and the pending flag; a pend set outranks a software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            ctrl_r  <= 4'd0;
            count_r <= 32'd0;
            pend_r  <= 1'b0;
        end else begin
            ctrl_r <= ctrl_next_s;
            if (wr_ctrl_s || wr_preset_s) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
            case (state_r)
                IDLE: begin
                    if (ctrl_r[0]) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    count_r <= preset_r;
                    state_r <= CNT;
                end
                CNT: begin
                    if (!ctrl_r[0]) begin
                        state_r <= IDLE;
                    end else if (count_r == 32'd0) begin
                        state_r <= INT;
                        pend_r  <= 1'b1;
                    end else begin
                        count_r <= count_r - 32'd1;
                    end
                end
                INT: begin
                    if (one_shot_s) begin
                        state_r <= IDLE;
                    end else begin
                        pend_r  <= 1'b0;
                        state_r <= LOAD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Word readback of the addressed register; the reserved slot reads zero.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            OFS_CTRL:   rdata = {28'd0, ctrl_r};
            OFS_PRESET: rdata = preset_r;
            OFS_COUNT:  rdata = count_r;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expected values are queued when the
// stimulus is applied and popped when the corresponding output is sampled.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int          n_cmp;
    int          n_err;
    logic [31:0] sb_q[$];

    timer_counter dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus store; returns just after the write edge.
    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        addr   = a;
        we     = 1'b1;
        byteen = be;
        wdata  = d;
        tick();
        we     = 1'b0;
        byteen = 4'b0000;
        wdata  = 32'd0;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: observed %h, nothing queued", tag, obs);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs === exp_v) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
        sb_q.push_back(e);
        addr = a;
        #1;
        cmp(tag, rdata);
    endtask

    task automatic chk_irq(input string tag, input logic e);
        sb_q.push_back({31'd0, e});
        cmp(tag, {31'd0, irq});
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        addr   = 2'd0;
        we     = 1'b0;
        byteen = 4'b0000;
        wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk_reg("rst_ctrl",   2'd0, 32'd0);
        chk_reg("rst_preset", 2'd1, 32'd0);
        chk_reg("rst_count",  2'd2, 32'd0);
        chk_reg("rst_resv",   2'd3, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // Readback and byte merging
        wr(2'd1, 4'b1111, 32'h1234_5678);
        chk_reg("preset_full", 2'd1, 32'h1234_5678);
        wr(2'd1, 4'b0100, 32'hAAAA_AAAA);
        chk_reg("preset_byte2", 2'd1, 32'h12AA_5678);
        wr(2'd1, 4'b0000, 32'hFFFF_FFFF);
        chk_reg("preset_be0", 2'd1, 32'h12AA_5678);
        wr(2'd3, 4'b1111, 32'hDEAD_BEEF);
        chk_reg("resv_wr", 2'd3, 32'd0);
        wr(2'd2, 4'b1111, 32'hDEAD_BEEF);
        chk_reg("count_ro", 2'd2, 32'd0);
        wr(2'd0, 4'b1111, 32'hFFFF_FFF6);
        chk_reg("ctrl_mask", 2'd0, 32'd6);
        wr(2'd0, 4'b1111, 32'd0);

        // One-shot, PRESET=3: irq at edge 6, EN cleared at edge 7
        wr(2'd1, 4'b1111, 32'd3);
        wr(2'd0, 4'b1111, 32'h9);
        tick();
        tick();
        chk_reg("os_cnt_e2", 2'd2, 32'd3);
        tick();
        chk_reg("os_cnt_e3", 2'd2, 32'd2);
        tick();
        chk_reg("os_cnt_e4", 2'd2, 32'd1);
        tick();
        chk_reg("os_cnt_e5", 2'd2, 32'd0);
        chk_irq("os_irq_e5", 1'b0);
        tick();
        chk_irq("os_irq_e6", 1'b1);
        chk_reg("os_ctrl_e6", 2'd0, 32'h9);
        tick();
        chk_reg("os_ctrl_e7", 2'd0, 32'h8);
        chk_irq("os_irq_e7", 1'b1);
        repeat (3) tick();
        chk_irq("os_irq_hold", 1'b1);
        chk_reg("os_cnt_hold", 2'd2, 32'd0);
        wr(2'd0, 4'b0001, 32'd0);
        chk_irq("os_irq_clr", 1'b0);

        // Auto-reload, PRESET=2: one-cycle pulses every 5 cycles
        wr(2'd1, 4'b1111, 32'd2);
        wr(2'd0, 4'b1111, 32'hB);
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk_irq($sformatf("ar_irq_e%0d", e), (e == 5) || (e == 10) || (e == 15));
        end
        wr(2'd0, 4'b0001, 32'd0);
        repeat (2) tick();

        // Masked interrupt with PRESET=0: INT at edge 3, no wrap
        wr(2'd1, 4'b1111, 32'd0);
        wr(2'd0, 4'b1111, 32'h1);
        tick();
        chk_irq("mk_irq_e1", 1'b0);
        tick();
        chk_reg("mk_cnt_e2", 2'd2, 32'd0);
        tick();
        chk_reg("mk_ctrl_e3", 2'd0, 32'h1);
        chk_irq("mk_irq_e3", 1'b0);
        tick();
        chk_reg("mk_ctrl_e4", 2'd0, 32'h0);
        chk_reg("mk_cnt_e4", 2'd2, 32'd0);
        repeat (2) tick();
        chk_reg("mk_nowrap", 2'd2, 32'd0);

        // Pause at COUNT=5: one more decrement at the write edge, then frozen
        wr(2'd1, 4'b1111, 32'd10);
        wr(2'd0, 4'b1111, 32'h1);
        repeat (7) tick();
        chk_reg("pz_cnt_e7", 2'd2, 32'd5);
        wr(2'd0, 4'b0001, 32'd0);
        chk_reg("pz_cnt_wr", 2'd2, 32'd4);
        tick();
        chk_reg("pz_cnt_idle", 2'd2, 32'd4);
        repeat (3) tick();
        chk_reg("pz_cnt_frozen", 2'd2, 32'd4);

        // PRESET write mid-count only affects the next LOAD
        wr(2'd0, 4'b1111, 32'h1);
        tick();
        tick();
        chk_reg("rt_cnt_e2", 2'd2, 32'd10);
        tick();
        wr(2'd1, 4'b1111, 32'd7);
        chk_reg("rt_cnt_e4", 2'd2, 32'd8);
        tick();
        tick();
        chk_reg("rt_cnt_e6", 2'd2, 32'd6);
        wr(2'd0, 4'b0001, 32'd0);
        repeat (2) tick();
        chk_reg("rt_cnt_stop", 2'd2, 32'd5);
        wr(2'd0, 4'b1111, 32'h1);
        tick();
        tick();
        chk_reg("rt_cnt_reload", 2'd2, 32'd7);
        wr(2'd0, 4'b0001, 32'd0);
        repeat (2) tick();

        // Software EN write in the one-shot INT cycle keeps EN and reloads
        wr(2'd1, 4'b1111, 32'd1);
        wr(2'd0, 4'b1111, 32'h1);
        repeat (4) tick();
        wr(2'd0, 4'b0001, 32'h1);
        chk_reg("cf_ctrl_keep", 2'd0, 32'h1);
        tick();
        chk_reg("cf_cnt_e6", 2'd2, 32'd0);
        tick();
        chk_reg("cf_cnt_reload", 2'd2, 32'd1);
        wr(2'd0, 4'b0001, 32'd0);
        repeat (2) tick();

        // CTRL write in the CNT->INT cycle: pend set wins over the clear
        wr(2'd0, 4'b1111, 32'h9);
        repeat (3) tick();
        wr(2'd0, 4'b0001, 32'h9);
        chk_irq("cf_pend_set", 1'b1);
        tick();
        chk_irq("cf_pend_hold", 1'b1);
        chk_reg("cf_ctrl_en0", 2'd0, 32'h8);

        // Asynchronous reset with irq high, between clock edges
        #2;
        reset = 1'b1;
        #1;
        chk_irq("ar1_irq", 1'b0);
        chk_reg("ar1_ctrl", 2'd0, 32'd0);
        chk_reg("ar1_preset", 2'd1, 32'd0);
        reset = 1'b0;

        // Asynchronous reset mid-count
        wr(2'd1, 4'b1111, 32'd20);
        wr(2'd0, 4'b1111, 32'h9);
        repeat (5) tick();
        chk_reg("ar2_cnt_pre", 2'd2, 32'd17);
        reset = 1'b1;
        #1;
        chk_reg("ar2_cnt", 2'd2, 32'd0);
        chk_reg("ar2_preset", 2'd1, 32'd0);
        chk_reg("ar2_ctrl", 2'd0, 32'd0);
        chk_irq("ar2_irq", 1'b0);
        reset = 1'b0;
        repeat (3) tick();
        chk_reg("ar2_cnt_after", 2'd2, 32'd0);
        chk_reg("ar2_ctrl_after", 2'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
